// File: rtl/my_mult_datapath.sv
// Shift-and-add unsigned 32x32 multiplier datapath.
// Holds the multiplicand, the 64-bit product/multiplier register, the ALU carry-out
// and the iteration count. All sequencing is done by an external controller through
// load / write / shift_right, so this block behaves sensibly under any control order.
module my_mult_datapath (
  input  logic        clk_i,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [31:0] multiplicand_i,
  input  logic [31:0] multiplier_i,
  input  logic        add_product_i,
  input  logic        write_i,
  input  logic        shift_right_i,
  output logic        product_0_o,
  output logic        is_32_o,
  output logic [63:0] product_o,
  output logic        product_valid_o
);

  localparam logic [5:0] IterLast = 6'd31;
  localparam logic [5:0] IterDone = 6'd32;

  logic [31:0] mcand_q, mcand_d;
  logic [63:0] product_q, product_d;
  logic        carry_q, carry_d;
  logic [5:0]  count_q, count_d;
  logic        valid_q, valid_d;

  logic [32:0] sum33;
  logic        at_max;
  logic        do_shift;

  // ALU: upper product half plus either the multiplicand or zero, carry kept in bit 32.
  always_comb begin
    sum33 = {1'b0, product_q[63:32]} + (add_product_i ? {1'b0, mcand_q} : 33'd0);
  end

  // Shifts stop once 32 iterations are done; writes are still honoured.
  always_comb begin
    at_max   = (count_q == IterDone);
    do_shift = shift_right_i && !at_max;
  end

  // Next-state selection: load wins, then the write/shift combination.
  always_comb begin
    mcand_d   = mcand_q;
    product_d = product_q;
    carry_d   = carry_q;
    count_d   = count_q;
    valid_d   = valid_q;

    if (load_i) begin
      mcand_d   = multiplicand_i;
      product_d = {32'd0, multiplier_i};
      carry_d   = 1'b0;
      count_d   = 6'd0;
      valid_d   = 1'b0;
    end else begin
      case ({write_i, do_shift})
        2'b10: begin
          carry_d           = sum33[32];
          product_d[63:32]  = sum33[31:0];
        end
        2'b01: begin
          // {carry, product} shifted right as one 65-bit quantity.
          product_d = {carry_q, product_q[63:1]};
          carry_d   = 1'b0;
          count_d   = count_q + 6'd1;
        end
        2'b11: begin
          // The freshly written 65-bit value is shifted in the same cycle.
          product_d = {sum33, product_q[31:1]};
          carry_d   = 1'b0;
          count_d   = count_q + 6'd1;
        end
        default: ;
      endcase

      if (do_shift && (count_q == IterLast)) begin
        valid_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      mcand_q   <= 32'd0;
      product_q <= 64'd0;
      carry_q   <= 1'b0;
      count_q   <= 6'd0;
      valid_q   <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      product_q <= product_d;
      carry_q   <= carry_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
    end
  end

  // Outputs come straight from the registers.
  always_comb begin
    product_o       = product_q;
    product_0_o     = product_q[0];
    is_32_o         = at_max;
    product_valid_o = valid_q;
  end

endmodule
